// File: rtl/f_pulse_counter.sv
// Counts rising edges of the decode flag over fixed windows of WINDOW cycles and
// presents each window count on a valid/ready port with saturation and drop flags.
module f_pulse_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_i,
  input  logic             en_i,
  input  logic             cnt_ready_i,
  output logic [CNT_W-1:0] cnt_data_o,
  output logic             cnt_valid_o,
  output logic             sat_o,
  output logic             dropped_o,
  output logic             busy_o
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic             f_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] acc_q;
  logic             wsat_q;
  logic [CNT_W-1:0] cnt_data_q;
  logic             cnt_valid_q;
  logic             sat_q;
  logic             dropped_q;

  logic             rise_w;
  logic             acc_full_w;
  logic [CNT_W-1:0] acc_d;
  logic             wsat_d;
  logic             win_end_w;
  logic             xfer_w;
  logic             load_w;
  logic             drop_w;

  // acc_d / wsat_d already include this cycle's edge, so at window end they
  // are the final saturated count and the window's saturation bit.
  always_comb begin
    rise_w     = f_i & ~f_q;
    acc_full_w = (acc_q == CNT_MAX);
    acc_d      = (rise_w && !acc_full_w) ? acc_q + 1'b1 : acc_q;
    wsat_d     = wsat_q | (rise_w & acc_full_w);
    win_end_w  = (state_q == RUN) && en_i && (win_q == WIN_LAST);
    xfer_w     = cnt_valid_q & cnt_ready_i;
    load_w     = win_end_w & (~cnt_valid_q | cnt_ready_i);
    drop_w     = win_end_w & cnt_valid_q & ~cnt_ready_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f_q         <= 1'b0;
      win_q       <= '0;
      acc_q       <= '0;
      wsat_q      <= 1'b0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      f_q <= f_i;

      case (state_q)
        IDLE: begin
          if (en_i) begin
            state_q <= RUN;
            win_q   <= '0;
            acc_q   <= '0;
            wsat_q  <= 1'b0;
          end
        end
        RUN: begin
          // Leaving RUN throws the partial window away, even at its last cycle.
          if (!en_i) begin
            state_q <= IDLE;
            win_q   <= '0;
            acc_q   <= '0;
            wsat_q  <= 1'b0;
          end else if (win_end_w) begin
            win_q   <= '0;
            acc_q   <= '0;
            wsat_q  <= 1'b0;
          end else begin
            win_q   <= win_q + 1'b1;
            acc_q   <= acc_d;
            wsat_q  <= wsat_d;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load_w) begin
        cnt_data_q  <= acc_d;
        sat_q       <= wsat_d;
        cnt_valid_q <= 1'b1;
      end else if (xfer_w) begin
        cnt_valid_q <= 1'b0;
      end

      // A transfer that coincides with a new load leaves the drop flag alone.
      if (drop_w) begin
        dropped_q <= 1'b1;
      end else if (xfer_w && !load_w) begin
        dropped_q <= 1'b0;
      end
    end
  end

  assign cnt_data_o  = cnt_data_q;
  assign cnt_valid_o = cnt_valid_q;
  assign sat_o       = sat_q;
  assign dropped_o   = dropped_q;
  assign busy_o      = (state_q == RUN);

endmodule

// File: tb/tb_f_pulse_counter.sv
// Directed bench: a default-width instance for counting/handshake/reset and a
// 3-bit instance for saturation, all expectations hand-computed.
module tb_f_pulse_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       f_a = 1'b0, en_a = 1'b0, rdy_a = 1'b0;
  logic [7:0] data_a;
  logic       valid_a, sat_a, drop_a, busy_a;

  logic       f_b = 1'b0, en_b = 1'b0, rdy_b = 1'b0;
  logic [2:0] data_b;
  logic       valid_b, sat_b, drop_b, busy_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  f_pulse_counter #(.CNT_W(8), .WINDOW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .f_i(f_a), .en_i(en_a), .cnt_ready_i(rdy_a),
    .cnt_data_o(data_a), .cnt_valid_o(valid_a), .sat_o(sat_a),
    .dropped_o(drop_a), .busy_o(busy_a)
  );

  f_pulse_counter #(.CNT_W(3), .WINDOW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .f_i(f_b), .en_i(en_b), .cnt_ready_i(rdy_b),
    .cnt_data_o(data_b), .cnt_valid_o(valid_b), .sat_o(sat_b),
    .dropped_o(drop_b), .busy_o(busy_b)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Drive inputs for one cycle, clock it, return 1 time unit after the edge.
  task automatic cyc_a(input logic f, input logic en, input logic rdy);
    f_a = f; en_a = en; rdy_a = rdy;
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input logic f, input logic en, input logic rdy);
    f_b = f; en_b = en; rdy_b = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_data", int'(data_a), 0);
    check_val("rst_valid", int'(valid_a), 0);
    check_val("rst_sat", int'(sat_a), 0);
    check_val("rst_dropped", int'(drop_a), 0);
    check_val("rst_busy", int'(busy_a), 0);
    rst_n = 1'b1;

    // Toggle counting, ready held high
    cyc_a(1'b0, 1'b1, 1'b1);
    check_val("tog_busy", int'(busy_a), 1);
    for (int i = 0; i < 16; i++) begin
      cyc_a((i % 2) == 0, 1'b1, 1'b1);
      if (i == 14) check_val("tog_w1_novalid", int'(valid_a), 0);
    end
    check_val("tog_w1_valid", int'(valid_a), 1);
    check_val("tog_w1_data", int'(data_a), 8);
    check_val("tog_w1_sat", int'(sat_a), 0);
    for (int i = 0; i < 16; i++) begin
      cyc_a((i % 2) == 0, 1'b1, 1'b1);
      if (i == 0) check_val("tog_pulse_end", int'(valid_a), 0);
    end
    check_val("tog_w2_valid", int'(valid_a), 1);
    check_val("tog_w2_data", int'(data_a), 8);

    // Level hold: f low before en, then held high
    cyc_a(1'b0, 1'b0, 1'b1);
    check_val("lvl_idle_busy", int'(busy_a), 0);
    check_val("lvl_idle_valid", int'(valid_a), 0);
    cyc_a(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cyc_a(1'b1, 1'b1, 1'b1);
    check_val("lvl_w1_data", int'(data_a), 1);
    check_val("lvl_w1_valid", int'(valid_a), 1);
    for (int i = 0; i < 16; i++) cyc_a(1'b1, 1'b1, 1'b1);
    check_val("lvl_w2_data", int'(data_a), 0);
    check_val("lvl_w2_valid", int'(valid_a), 1);

    // Backpressure: 8 edges then 5 edges with ready low
    for (int i = 0; i < 16; i++) begin
      cyc_a((i % 2) == 1, 1'b1, i == 0);
      if (i == 0) check_val("bp_consumed", int'(valid_a), 0);
    end
    check_val("bp_w1_data", int'(data_a), 8);
    check_val("bp_w1_dropped", int'(drop_a), 0);
    for (int i = 0; i < 16; i++) cyc_a(((i % 2) == 1) && (i < 10), 1'b1, 1'b0);
    check_val("bp_w2_data", int'(data_a), 8);
    check_val("bp_w2_valid", int'(valid_a), 1);
    check_val("bp_w2_dropped", int'(drop_a), 1);
    cyc_a(1'b0, 1'b0, 1'b1);
    check_val("bp_xfer_valid", int'(valid_a), 0);
    check_val("bp_xfer_dropped", int'(drop_a), 0);
    check_val("bp_xfer_busy", int'(busy_a), 0);

    // Transfer coinciding with window end
    cyc_a(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc_a((i % 2) == 0, 1'b1, 1'b0);
    check_val("sim_w1_data", int'(data_a), 8);
    for (int i = 0; i < 16; i++) begin
      cyc_a((i == 1) || (i == 3) || (i == 5), 1'b1, i == 15);
      if (i == 14) check_val("sim_hold_data", int'(data_a), 8);
    end
    check_val("sim_valid", int'(valid_a), 1);
    check_val("sim_data", int'(data_a), 3);
    check_val("sim_dropped", int'(drop_a), 0);

    // en dropped at win = 7 discards the partial window
    for (int i = 0; i < 8; i++) cyc_a((i % 2) == 0, i != 7, 1'b1);
    check_val("abort_busy", int'(busy_a), 0);
    for (int i = 0; i < 20; i++) cyc_a(1'b0, 1'b0, 1'b1);
    check_val("abort_novalid", int'(valid_a), 0);
    check_val("abort_data", int'(data_a), 3);

    // Asynchronous reset mid-window with a pending result
    cyc_a(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc_a((i % 2) == 0, 1'b1, 1'b0);
    check_val("ar_pre_valid", int'(valid_a), 1);
    for (int i = 0; i < 5; i++) cyc_a((i % 2) == 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    check_val("ar_data", int'(data_a), 0);
    check_val("ar_valid", int'(valid_a), 0);
    check_val("ar_busy", int'(busy_a), 0);
    check_val("ar_dropped", int'(drop_a), 0);
    check_val("ar_sat", int'(sat_a), 0);
    cyc_a(1'b0, 1'b1, 1'b0);
    cyc_a(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc_a(1'b0, 1'b1, 1'b0);
    check_val("ar_rerun_busy", int'(busy_a), 1);
    for (int i = 0; i < 15; i++) cyc_a(1'b0, 1'b1, 1'b0);
    check_val("ar_no_early_valid", int'(valid_a), 0);
    cyc_a(1'b0, 1'b1, 1'b0);
    check_val("ar_first_valid", int'(valid_a), 1);
    check_val("ar_first_data", int'(data_a), 0);
    cyc_a(1'b0, 1'b0, 1'b1);

    // Saturation on the 3-bit instance
    cyc_b(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cyc_b((i % 2) == 0, 1'b1, 1'b1);
    check_val("sat_w1_data", int'(data_b), 7);
    check_val("sat_w1_sat", int'(sat_b), 1);
    check_val("sat_w1_valid", int'(valid_b), 1);
    for (int i = 0; i < 16; i++) cyc_b((i == 1) || (i == 3), 1'b1, 1'b1);
    check_val("sat_w2_data", int'(data_b), 2);
    check_val("sat_w2_sat", int'(sat_b), 0);
    check_val("sat_w2_dropped", int'(drop_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
